// File: rtl/cpu_defs.sv
// Shared CPU definitions: data-path widths, arbiter state encoding and the
// rule that decides when a dual-pipe bundle must be split across two cycles.
package cpu_defs;

  localparam int unsigned AW_DEF   = 32;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned CNTW_DEF = 16;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SLV_PEND = 1'b1;

  // Two reads of one address can share a single memory access; any other
  // pair of requests needs the port twice.
  function automatic logic needs_serialize(input logic m_req,
                                           input logic m_we,
                                           input logic s_req,
                                           input logic s_we,
                                           input logic addr_eq);
    return m_req && s_req && !(!m_we && !s_we && addr_eq);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the master and slave MEM stages.
// Conflicting bundles serve the master first and the slave one cycle later.
module dmem_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_req_i,
  input  logic            m_we_i,
  input  logic [AW-1:0]   m_addr_i,
  input  logic [DW-1:0]   m_wdata_i,
  output logic [DW-1:0]   m_rdata_o,
  input  logic            s_req_i,
  input  logic            s_we_i,
  input  logic [AW-1:0]   s_addr_i,
  input  logic [DW-1:0]   s_wdata_i,
  output logic [DW-1:0]   s_rdata_o,
  output logic            stall_o,
  output logic [3:0]      mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic [CNTW-1:0] conflict_cnt_o
);

  logic [0:0]      state_q, state_d;
  logic            pend_we_q, pend_we_d;
  logic [AW-1:0]   pend_addr_q, pend_addr_d;
  logic [DW-1:0]   pend_wdata_q, pend_wdata_d;
  logic [DW-1:0]   m_hold_q, m_hold_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic addr_eq;
  logic serialize;

  assign addr_eq   = (m_addr_i == s_addr_i);
  // Depends only on state and request fields, never on mem_rdata_i.
  assign serialize = (state_q == ST_IDLE) &&
                     needs_serialize(m_req_i, m_we_i, s_req_i, s_we_i, addr_eq);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    stall_o     = 1'b0;
    mem_we_o    = 4'h0;
    mem_addr_o  = m_addr_i;
    mem_wdata_o = m_wdata_i;
    m_rdata_o   = mem_rdata_i;
    s_rdata_o   = mem_rdata_i;

    case (state_q)
      ST_IDLE: begin
        if (m_req_i) begin
          mem_we_o = {4{m_we_i}};
          if (serialize) begin
            stall_o = 1'b1;
            state_d = ST_SLV_PEND;
          end
        end else if (s_req_i) begin
          mem_addr_o  = s_addr_i;
          mem_wdata_o = s_wdata_i;
          mem_we_o    = {4{s_we_i}};
        end
      end
      ST_SLV_PEND: begin
        mem_addr_o  = pend_addr_q;
        mem_wdata_o = pend_wdata_q;
        mem_we_o    = {4{pend_we_q}};
        m_rdata_o   = m_hold_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Held in reset: no stall and no memory write, whatever the pipes request.
    if (!rst) begin
      stall_o  = 1'b0;
      mem_we_o = 4'h0;
    end
  end

  assign pend_we_d    = serialize ? s_we_i      : pend_we_q;
  assign pend_addr_d  = serialize ? s_addr_i    : pend_addr_q;
  assign pend_wdata_d = serialize ? s_wdata_i   : pend_wdata_q;
  assign m_hold_d     = serialize ? mem_rdata_i : m_hold_q;
  assign cnt_d        = (serialize && !(&cnt_q)) ? cnt_q + CNTW'(1'b1) : cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      m_hold_q     <= '0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      m_hold_q     <= m_hold_d;
      cnt_q        <= cnt_d;
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: bundles are resolved in program
// order against a word-array model and the expected results queued for a monitor.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_req, m_we, s_req, s_we;
  logic [31:0] m_addr, m_wdata, s_addr, s_wdata;
  logic [31:0] m_rdata, s_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall;
  logic [3:0]  mem_we;
  logic [15:0] cnt;

  logic [31:0] u2_m_rdata, u2_s_rdata, u2_mem_addr, u2_mem_wdata;
  logic        u2_stall;
  logic [3:0]  u2_mem_we;
  logic [1:0]  u2_cnt;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
    .s_req_i(s_req), .s_we_i(s_we), .s_addr_i(s_addr), .s_wdata_i(s_wdata), .s_rdata_o(s_rdata),
    .stall_o(stall), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .conflict_cnt_o(cnt)
  );

  dmem_arbiter #(.CNTW(2)) dut_sat (
    .clk(clk), .rst(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rdata_o(u2_m_rdata),
    .s_req_i(s_req), .s_we_i(s_we), .s_addr_i(s_addr), .s_wdata_i(s_wdata), .s_rdata_o(u2_s_rdata),
    .stall_o(u2_stall), .mem_we_o(u2_mem_we), .mem_addr_o(u2_mem_addr), .mem_wdata_o(u2_mem_wdata),
    .mem_rdata_i(mem_rdata), .conflict_cnt_o(u2_cnt)
  );

  always #5 clk = ~clk;

  // Data memory on the falling edge, driven by the main instance.
  logic [31:0] tb_mem [256];
  always @(negedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) tb_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= tb_mem[mem_addr[9:2]];
  end

  typedef struct {
    int          stalls;
    logic [3:0]  we_stall;
    logic [3:0]  we_final;
    logic        addr_chk;
    logic [31:0] addr_final;
    logic [31:0] wdata_final;
    logic        m_rd;
    logic        s_rd;
    logic [31:0] m_rdata;
    logic [31:0] s_rdata;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mdl [256];
  int          cnt_mdl  = 0;
  int          cnt2_mdl = 0;
  int          n_cmp    = 0;
  int          n_fail   = 0;
  int          stall_run = 0;
  logic        mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the bundle is master-then-slave in program order; it costs one
  // extra cycle unless it is a single request or two reads of one address.
  task automatic drive_bundle(input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] md,
                              input logic sr, input logic sw, input logic [31:0] sa, input logic [31:0] sd);
    exp_t e;
    logic split;
    @(posedge clk); #1;
    m_req = mr; m_we = mw; m_addr = ma; m_wdata = md;
    s_req = sr; s_we = sw; s_addr = sa; s_wdata = sd;

    split      = mr && sr && (mw || sw || (ma != sa));
    e.stalls   = split ? 1 : 0;
    e.we_stall = (mr && mw) ? 4'hF : 4'h0;
    e.m_rd = 1'b0; e.s_rd = 1'b0; e.m_rdata = '0; e.s_rdata = '0;
    if (split) begin
      e.we_final    = sw ? 4'hF : 4'h0;
      e.addr_chk    = 1'b1;
      e.addr_final  = sa;
      e.wdata_final = sd;
    end else begin
      e.we_final    = ((mr && mw) || (sr && sw)) ? 4'hF : 4'h0;
      e.addr_chk    = mr || sr;
      e.addr_final  = mr ? ma : sa;
      e.wdata_final = mr ? md : sd;
    end
    if (mr) begin
      if (mw) mdl[ma[9:2]] = md;
      else begin e.m_rd = 1'b1; e.m_rdata = mdl[ma[9:2]]; end
    end
    if (sr) begin
      if (sw) mdl[sa[9:2]] = sd;
      else begin e.s_rd = 1'b1; e.s_rdata = mdl[sa[9:2]]; end
    end
    if (split) begin
      if (cnt_mdl < 65535) cnt_mdl++;
      if (cnt2_mdl < 3) cnt2_mdl++;
    end
    e.cnt  = 16'(cnt_mdl);
    e.cnt2 = 2'(cnt2_mdl);
    exp_q.push_back(e);

    // A stalled pipeline holds its bundle; the stall wait is bounded.
    @(negedge clk); #3;
    for (int g = 0; g < 3 && stall; g++) begin
      @(negedge clk); #3;
    end
  endtask

  task automatic random_bundles(input int n);
    logic [31:0] ma, sa;
    for (int i = 0; i < n; i++) begin
      ma = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      sa = ($urandom_range(0, 3) == 0) ? ma : {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      drive_bundle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ma, $urandom,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, sa, $urandom);
    end
  endtask

  // Monitor: counts stall cycles and compares when a bundle completes.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        if (stall) begin
          stall_run++;
          check("stall_without_bundle", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("we_stall_cycle", 32'(mem_we), 32'(exp_q[0].we_stall));
            check("sat_we_stall_cycle", 32'(u2_mem_we), 32'(exp_q[0].we_stall));
          end
          check("sat_stall_cycle", 32'(u2_stall), 32'd1);
        end else if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("stall_cycles", 32'(stall_run), 32'(mon_e.stalls));
          check("sat_stall_final", 32'(u2_stall), 32'd0);
          check("mem_we", 32'(mem_we), 32'(mon_e.we_final));
          check("sat_mem_we", 32'(u2_mem_we), 32'(mon_e.we_final));
          if (mon_e.addr_chk) begin
            check("mem_addr", mem_addr, mon_e.addr_final);
            check("sat_mem_addr", u2_mem_addr, mon_e.addr_final);
          end
          if (mon_e.we_final != 4'h0) begin
            check("mem_wdata", mem_wdata, mon_e.wdata_final);
            check("sat_mem_wdata", u2_mem_wdata, mon_e.wdata_final);
          end
          if (mon_e.m_rd) begin
            check("m_rdata", m_rdata, mon_e.m_rdata);
            check("sat_m_rdata", u2_m_rdata, mon_e.m_rdata);
          end
          if (mon_e.s_rd) begin
            check("s_rdata", s_rdata, mon_e.s_rdata);
            check("sat_s_rdata", u2_s_rdata, mon_e.s_rdata);
          end
          check("conflict_cnt", 32'(cnt), 32'(mon_e.cnt));
          check("sat_conflict_cnt", 32'(u2_cnt), 32'(mon_e.cnt2));
          stall_run = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d bundles outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 32'h0;
      mdl[i]    = 32'h0;
    end
    // Conflicting requests held through reset must not stall or write.
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h8; m_wdata = 32'hDEAD;
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'hC; s_wdata = 32'hBEEF;
    @(negedge clk); #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_cnt", 32'(cnt), 32'd0);
    check("reset_sat_cnt", 32'(u2_cnt), 32'd0);
    m_req = 1'b0; s_req = 1'b0; m_we = 1'b0; s_we = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Directed bundles.
    drive_bundle(1, 1, 32'h10, 32'h1234, 0, 0, 32'h0, 32'h0);     // master sw
    drive_bundle(1, 0, 32'h10, 32'h0,    0, 0, 32'h0, 32'h0);     // master lw
    drive_bundle(1, 0, 32'h20, 32'h0,    1, 0, 32'h20, 32'h0);    // dual lw same addr
    drive_bundle(1, 1, 32'h30, 32'hAA,   1, 0, 32'h30, 32'h0);    // sw then lw same addr
    drive_bundle(1, 1, 32'h40, 32'h55,   0, 0, 32'h0, 32'h0);
    drive_bundle(1, 0, 32'h40, 32'h0,    1, 1, 32'h44, 32'h66);   // lw held, slave sw
    drive_bundle(0, 0, 32'h0,  32'h0,    1, 0, 32'h44, 32'h0);    // slave-only lw
    drive_bundle(0, 0, 32'h0,  32'h0,    0, 0, 32'h0, 32'h0);     // idle

    random_bundles(300);

    // Reset while the slave store is pending.
    mon_en = 1'b0;
    @(posedge clk); #1;
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h50; m_wdata = 32'h77;
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h54; s_wdata = 32'h99;
    @(negedge clk); #2;
    check("rst_test_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("rst_test_pend_addr", mem_addr, 32'h54);
    rst = 1'b0;
    #1;
    check("rst_test_stall_in_reset", 32'(stall), 32'd0);
    check("rst_test_we_in_reset", 32'(mem_we), 32'd0);
    check("rst_test_cnt", 32'(cnt), 32'd0);
    check("rst_test_sat_cnt", 32'(u2_cnt), 32'd0);
    @(negedge clk); @(negedge clk); #1;
    check("rst_test_slave_word", tb_mem[8'h15], 32'h0);
    check("rst_test_master_word", tb_mem[8'h14], 32'h77);
    @(posedge clk); #1;
    m_req = 1'b0; s_req = 1'b0; m_we = 1'b0; s_we = 1'b0;
    rst = 1'b1;
    mdl[8'h14] = 32'h77;
    cnt_mdl    = 0;
    cnt2_mdl   = 0;
    @(negedge clk); #1;
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_slave_word", tb_mem[8'h15], 32'h0);
    mon_en = 1'b1;

    random_bundles(60);

    @(negedge clk); #4;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 256; i++)
      check($sformatf("mem_word_%0d", i), tb_mem[i], mdl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
